// File: rtl/sat_enh_pkg.sv
// Shared constants and types for the saturation-enhance round/clamp stage.
// Default widths match the gain multiplier output feeding this block.
package sat_enh_pkg;

    localparam int unsigned CH_DEF     = 3;
    localparam int unsigned PROD_W_DEF = 27;
    localparam int unsigned OUT_W_DEF  = 8;
    localparam int unsigned SHIFT_DEF  = 11;

    localparam int unsigned RND_C = 1 << (SHIFT_DEF - 1);
    localparam int unsigned SUM_W = PROD_W_DEF + 1;

    typedef logic [PROD_W_DEF-1:0] prod_t;
    typedef logic [OUT_W_DEF-1:0]  pix_t;

endpackage

// File: rtl/sat_enh_chan_rnd.sv
// Single-channel round-half-up and right shift of an unsigned gain product.
// Purely combinational; the result keeps all integer bits so the caller can clamp.
module sat_enh_chan_rnd
    import sat_enh_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned SHIFT  = SHIFT_DEF
) (
    input  logic [PROD_W-1:0]     p,
    output logic [PROD_W-SHIFT:0] q
);

    localparam logic [PROD_W:0] RND = {{PROD_W{1'b0}}, 1'b1} << (SHIFT - 1);

    logic [PROD_W:0]  r;
    logic [SHIFT-1:0] frac_unused;

    // One extra sum bit so adding the rounding constant can never overflow.
    assign r = {1'b0, p} + RND;
    assign {q, frac_unused} = r;

endmodule

// File: rtl/sat_enh_round_clamp.sv
// Round, shift and clamp CH gain products to OUT_W-bit pixels over AXI4-Stream.
// Define SAT_ENH_CLIP_CNT_EN to build the sticky clip_count statistic.
module sat_enh_round_clamp
    import sat_enh_pkg::*;
#(
    parameter int unsigned CH     = CH_DEF,
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned SHIFT  = SHIFT_DEF
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [CH*PROD_W-1:0]   s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tuser,
    input  logic                   s_tlast,
    output logic [CH*OUT_W-1:0]    m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tuser,
    output logic                   m_tlast,
    input  logic                   clip_clr,
    output logic [31:0]            clip_count
);

    localparam int unsigned Q_W     = PROD_W + 1 - SHIFT;
    localparam int unsigned PIX_MAX = (1 << OUT_W) - 1;

    logic [CH*Q_W-1:0]   rnd_q;
    logic [CH*Q_W-1:0]   s1_q;
    logic                s1_user;
    logic                s1_last;
    logic                v1;
    logic                v2;
    logic                en1;
    logic                en2;
    logic [CH*OUT_W-1:0] clamp_d;
    logic                clip_any;

    for (genvar g = 0; g < CH; g++) begin : g_rnd
        sat_enh_chan_rnd #(.PROD_W(PROD_W), .SHIFT(SHIFT)) u_rnd (
            .p (s_tdata[g*PROD_W +: PROD_W]),
            .q (rnd_q[g*Q_W +: Q_W])
        );
    end

    // An empty stage always accepts, so bubbles collapse under backpressure.
    assign en2      = ~v2 | m_tready;
    assign en1      = ~v1 | en2;
    assign s_tready = en1;
    assign m_tvalid = v2;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1      <= 1'b0;
            s1_q    <= '0;
            s1_user <= 1'b0;
            s1_last <= 1'b0;
        end else if (en1) begin
            v1 <= s_tvalid;
            if (s_tvalid) begin
                s1_q    <= rnd_q;
                s1_user <= s_tuser;
                s1_last <= s_tlast;
            end
        end
    end

    always_comb begin
        clamp_d  = '0;
        clip_any = 1'b0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (s1_q[c*Q_W +: Q_W] > Q_W'(PIX_MAX)) begin
                clamp_d[c*OUT_W +: OUT_W] = '1;
                clip_any                  = 1'b1;
            end else begin
                clamp_d[c*OUT_W +: OUT_W] = s1_q[c*Q_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v2      <= 1'b0;
            m_tdata <= '0;
            m_tuser <= 1'b0;
            m_tlast <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                m_tdata <= clamp_d;
                m_tuser <= s1_user;
                m_tlast <= s1_last;
            end
        end
    end

`ifdef SAT_ENH_CLIP_CNT_EN
    logic        clip2;
    logic [31:0] clip_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            clip2 <= 1'b0;
        end else if (en2 && v1) begin
            clip2 <= clip_any;
        end
    end

    // Clear has priority over a same-cycle increment; count saturates.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            clip_q <= '0;
        end else if (clip_clr) begin
            clip_q <= '0;
        end else if (v2 && m_tready && clip2 && (clip_q != '1)) begin
            clip_q <= clip_q + 32'd1;
        end
    end

    assign clip_count = clip_q;
`else
    logic clip_unused;

    assign clip_unused = clip_clr | clip_any;
    assign clip_count  = '0;
`endif

endmodule
